// File: rtl/apb_master_ctrl.sv
// APB master: turns a valid/ready request and a one-cycle response pulse into
// IDLE -> SETUP -> ACCESS bus transfers, with an optional PREADY wait timeout.
module apb_master_ctrl #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    transfer,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic                    PWRITE,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state_reg;
    logic   accept;
    logic   complete;
    logic   timeout;

    // req_ready is held low while PRESET is asserted so every output reads 0 in reset.
    assign req_ready = !PRESET && ((state_reg == IDLE) || (state_reg == ACCESS && PREADY));
    assign accept    = transfer && req_ready;
    assign complete  = (state_reg == ACCESS) && PREADY;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT_CYCLES);
            localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

            logic [CNT_WIDTH-1:0] wait_cnt_reg;

            // Fires on the TIMEOUT_CYCLES-th ACCESS cycle that still sees PREADY low.
            assign timeout = (state_reg == ACCESS) && !PREADY && (wait_cnt_reg >= CNT_LAST);

            always_ff @(posedge PCLK or posedge PRESET) begin
                if (PRESET) begin
                    wait_cnt_reg <= '0;
                end else if (accept) begin
                    wait_cnt_reg <= '0;
                end else if (state_reg == ACCESS && !PREADY && wait_cnt_reg != CNT_MAX) begin
                    wait_cnt_reg <= wait_cnt_reg + CNT_WIDTH'(1);
                end
            end
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg   <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;

            // Accept is only possible from IDLE or a completing ACCESS cycle.
            if (accept) begin
                PADDR  <= req_addr;
                PWRITE <= req_write;
                PWDATA <= req_wdata;
                PSTRB  <= req_write ? req_strb : {STRB_WIDTH{1'b0}};
            end

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= SETUP;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                    end
                end
                SETUP: begin
                    state_reg <= ACCESS;
                    PSEL      <= 1'b1;
                    PENABLE   <= 1'b1;
                end
                ACCESS: begin
                    if (complete) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= PSLVERR;
                        if (accept) begin
                            state_reg <= SETUP;
                            PSEL      <= 1'b1;
                            PENABLE   <= 1'b0;
                        end else begin
                            state_reg <= IDLE;
                            PSEL      <= 1'b0;
                            PENABLE   <= 1'b0;
                            PSTRB     <= '0;
                        end
                    end else if (timeout) begin
                        state_reg   <= IDLE;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        PSTRB       <= '0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    PSTRB     <= '0;
                end
            endcase
        end
    end

    // Bus protocol invariants this master must never break.
    a_enable_implies_sel: assert property (@(posedge PCLK) disable iff (PRESET)
        PENABLE |-> PSEL);
    a_setup_then_access: assert property (@(posedge PCLK) disable iff (PRESET)
        (PSEL && !PENABLE) |=> (PSEL && PENABLE));
    a_hold_while_waiting: assert property (@(posedge PCLK) disable iff (PRESET)
        (state_reg == ACCESS && !PREADY && !timeout) |=>
        (PENABLE && $stable(PADDR) && $stable(PWRITE) && $stable(PWDATA) && $stable(PSTRB)));

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Scoreboard bench for apb_master_ctrl: directed requests push expected responses,
// a monitor pops and compares on every rsp_valid pulse.
module tb_apb_master_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        transfer;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic [7:0]  PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb_master_ctrl #(
        .ADDR_WIDTH    (8),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .transfer   (transfer),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_strb   (req_strb),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PADDR      (PADDR),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PSTRB      (PSTRB),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   rsp_cyc[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_rsp = 0;

    // Slave behaviour knobs, set per test
    int          wait_states = 0;
    logic        slv_err     = 1'b0;
    logic [31:0] rd_data     = 32'h0;
    int          acc_cnt     = 0;

    assign PRDATA = rd_data;

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Slave model: PREADY rises after wait_states ACCESS cycles.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            PREADY  = (acc_cnt >= wait_states);
            PSLVERR = slv_err && PREADY;
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
        end
    end

    // Response monitor / scoreboard
    always @(negedge PCLK) begin
        if (rsp_valid === 1'b1) begin
            exp_t e;
            rsp_cyc.push_back(cyc);
            n_rsp++;
            $display("rsp %0d: cyc=%0d rdata=0x%08h err=%0b timeout=%0b",
                     n_rsp, cyc, rsp_rdata, rsp_err, rsp_timeout);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response pending");
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata",   rsp_rdata,          e.rdata);
                check("rsp_err",     32'(rsp_err),       32'(e.err));
                check("rsp_timeout", 32'(rsp_timeout),   32'(e.to));
            end
        end else if (PRESET === 1'b0 && (rsp_err !== 1'b0 || rsp_timeout !== 1'b0)) begin
            check("rsp_flags_idle", {30'd0, rsp_err, rsp_timeout}, 32'd0);
        end
    end

    task automatic do_req(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input logic [31:0] e_rd,
                          input logic e_err, input logic e_to);
        int   n    = 0;
        bit   done = 0;
        exp_t e;
        transfer  = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        req_strb  = st;
        while (!done) begin
            @(posedge PCLK);
            if (req_ready === 1'b1) begin
                done    = 1;
                e.rdata = e_rd;
                e.err   = e_err;
                e.to    = e_to;
                exp_q.push_back(e);
                $display("req: %s addr=0x%02h wdata=0x%08h strb=0x%0h cyc=%0d",
                         wr ? "WR" : "RD", a, wd, st, cyc);
            end else if (++n > 100) begin
                done = 1;
                check("req_accept_budget", 32'(n), 32'd100);
            end
        end
        #1 transfer = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((PSEL !== 1'b0 || exp_q.size() != 0) && n < 60) begin
            @(negedge PCLK);
            n++;
        end
        check("idle_budget", 32'(n < 60), 32'd1);
        repeat (2) @(negedge PCLK);
    endtask

    initial begin
        int n;
        PRESET    = 1'b1;
        transfer  = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // Reset state
        repeat (2) @(negedge PCLK);
        check("rst_req_ready",   32'(req_ready),   32'd0);
        check("rst_psel",        32'(PSEL),        32'd0);
        check("rst_penable",     32'(PENABLE),     32'd0);
        check("rst_paddr",       32'(PADDR),       32'd0);
        check("rst_pwrite",      32'(PWRITE),      32'd0);
        check("rst_pwdata",      PWDATA,           32'd0);
        check("rst_pstrb",       32'(PSTRB),       32'd0);
        check("rst_rsp_valid",   32'(rsp_valid),   32'd0);
        check("rst_rsp_rdata",   rsp_rdata,        32'd0);
        check("rst_rsp_err",     32'(rsp_err),     32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        #1 PRESET = 1'b0;
        #1 check("post_rst_req_ready", 32'(req_ready), 32'd1);

        // 1. Write, no wait states
        wait_states = 0;
        rd_data     = 32'hFFFF_FFFF;
        do_req(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b0);
        @(negedge PCLK);
        check("t1_setup_psel",    32'(PSEL),    32'd1);
        check("t1_setup_penable", 32'(PENABLE), 32'd0);
        check("t1_paddr",         32'(PADDR),   32'h10);
        check("t1_pwrite",        32'(PWRITE),  32'd1);
        check("t1_pwdata",        PWDATA,       32'hDEAD_BEEF);
        check("t1_pstrb",         32'(PSTRB),   32'hF);
        @(negedge PCLK);
        check("t1_access_psel",    32'(PSEL),    32'd1);
        check("t1_access_penable", 32'(PENABLE), 32'd1);
        @(negedge PCLK);
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_idle_psel", 32'(PSEL),      32'd0);
        check("t1_idle_pstrb", 32'(PSTRB),    32'd0);
        wait_idle();

        // 2. Read with 3 wait states
        wait_states = 3;
        rd_data     = 32'h1234_5678;
        do_req(1'b0, 8'h24, 32'h5555_AAAA, 4'hF, 32'h1234_5678, 1'b0, 1'b0);
        @(negedge PCLK);
        check("t2_setup_penable", 32'(PENABLE), 32'd0);
        check("t2_setup_pstrb",   32'(PSTRB),   32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            check("t2_access_penable", 32'(PENABLE), 32'd1);
            check("t2_access_paddr",   32'(PADDR),   32'h24);
            check("t2_access_pwrite",  32'(PWRITE),  32'd0);
            check("t2_access_pstrb",   32'(PSTRB),   32'd0);
        end
        wait_idle();
        rd_data = 32'h0;
        repeat (3) @(negedge PCLK);
        check("t2_rdata_hold", rsp_rdata, 32'h1234_5678);

        // 3. Back-to-back write then read
        wait_states = 0;
        rd_data     = 32'hCAFE_F00D;
        rsp_cyc.delete();
        do_req(1'b1, 8'h30, 32'hA5A5_0001, 4'h3, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, 8'h34, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b0);
        @(negedge PCLK);
        check("t3_b2b_psel",    32'(PSEL),    32'd1);
        check("t3_b2b_penable", 32'(PENABLE), 32'd0);
        check("t3_b2b_paddr",   32'(PADDR),   32'h34);
        check("t3_b2b_pstrb",   32'(PSTRB),   32'd0);
        wait_idle();
        check("t3_rsp_count", 32'(rsp_cyc.size()), 32'd2);
        if (rsp_cyc.size() == 2)
            check("t3_rsp_spacing", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'd2);

        // 4. Slave error on write
        slv_err = 1'b1;
        do_req(1'b1, 8'h40, 32'h0000_0040, 4'h1, 32'h0, 1'b1, 1'b0);
        wait_idle();
        slv_err = 1'b0;

        // 5. Timeout after 16 ACCESS cycles
        wait_states = 1000;
        do_req(1'b0, 8'h50, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1);
        @(negedge PCLK);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (PENABLE !== 1'b1) break;
            n++;
        end
        check("t5_access_cycles", 32'(n),         32'd16);
        check("t5_psel_drop",     32'(PSEL),      32'd0);
        check("t5_rsp_timeout",   32'(rsp_timeout), 32'd1);
        wait_idle();

        // 6. Reset in the middle of ACCESS
        do_req(1'b0, 8'h60, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1);
        repeat (2) @(negedge PCLK);
        check("t6_in_access", 32'(PENABLE), 32'd1);
        #2 PRESET = 1'b1;
        exp_q.delete();
        #1;
        check("t6_rst_psel",      32'(PSEL),      32'd0);
        check("t6_rst_penable",   32'(PENABLE),   32'd0);
        check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge PCLK);
        #1 PRESET = 1'b0;
        #1 check("t6_post_req_ready", 32'(req_ready), 32'd1);
        repeat (5) @(negedge PCLK);
        check("t6_idle_psel", 32'(PSEL), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got simulation still running expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
